// File: rtl/can_rx_sequencer_if.sv
// Per-bit strobe from the unstuffer/CRC side and frame status back from the receive sequencer.
interface can_rx_sequencer_if #(
  parameter int CRC_BITS = 15
);
  logic                bit_valid;
  logic                bit_in;
  logic                stuff_err;
  logic [CRC_BITS-1:0] crc_remainder;
  logic                unstuff_en;
  logic                crc_clear;
  logic                crc_en;
  logic [10:0]         id;
  logic                rtr;
  logic [3:0]          dlc;
  logic [7:0]          data_byte;
  logic                data_valid;
  logic                ack_seen;
  logic                frame_done;
  logic                frame_err;
  logic [1:0]          err_code;

  modport slave (
    input  bit_valid, bit_in, stuff_err, crc_remainder,
    output unstuff_en, crc_clear, crc_en, id, rtr, dlc, data_byte, data_valid,
           ack_seen, frame_done, frame_err, err_code
  );

  modport master (
    output bit_valid, bit_in, stuff_err, crc_remainder,
    input  unstuff_en, crc_clear, crc_en, id, rtr, dlc, data_byte, data_valid,
           ack_seen, frame_done, frame_err, err_code
  );
endinterface

// File: rtl/can_rx_sequencer.sv
// CAN 2.0A base-frame receive sequencer: field tracking, unstuff/CRC gating, ID/DLC/data extraction, error flags.
// unstuff_en/crc_en/crc_clear are combinational so they gate the bit being strobed; all other outputs are registered.
module can_rx_sequencer #(
  parameter int CRC_BITS  = 15,
  parameter int IDLE_BITS = 11
) (
  input logic               clk,
  input logic               rst,
  can_rx_sequencer_if.slave bus
);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam int CW = ($clog2(CRC_BITS) > 4) ? $clog2(CRC_BITS) : 4;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT_SOF = 4'd1;
  localparam logic [3:0] S_ARB      = 4'd2;
  localparam logic [3:0] S_CTRL     = 4'd3;
  localparam logic [3:0] S_DATA     = 4'd4;
  localparam logic [3:0] S_CRC      = 4'd5;
  localparam logic [3:0] S_CRC_DEL  = 4'd6;
  localparam logic [3:0] S_ACK      = 4'd7;
  localparam logic [3:0] S_ACK_DEL  = 4'd8;
  localparam logic [3:0] S_EOF      = 4'd9;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_STUFF = 2'b01;
  localparam logic [1:0] E_FORM  = 2'b10;
  localparam logic [1:0] E_CRC   = 2'b11;

  logic [3:0]    state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bytes_q, bytes_d;
  logic [6:0]    shift_q, shift_d;
  logic [10:0]   id_q, id_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          data_valid_q, data_valid_d;
  logic          ack_seen_q, ack_seen_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic       sof;
  logic       in_frame;
  logic       err_hit;
  logic [1:0] err_kind;
  logic [3:0] dlc_next;
  logic [3:0] nbytes;

  // SOF is the dominant bit seen in WAIT_SOF; it is the first bit fed to the unstuffer and CRC.
  assign sof      = (state_q == S_WAIT_SOF) && bus.bit_valid && !bus.bit_in;
  assign in_frame = state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC};
  assign dlc_next = {dlc_q[2:0], bus.bit_in};
  assign nbytes   = rtr_q ? 4'd0 : ((dlc_next > 4'd8) ? 4'd8 : dlc_next);

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    cnt_d        = cnt_q;
    bytes_d      = bytes_q;
    shift_d      = shift_q;
    id_d         = id_q;
    rtr_d        = rtr_q;
    dlc_d        = dlc_q;
    data_byte_d  = data_byte_q;
    data_valid_d = 1'b0;
    ack_seen_d   = ack_seen_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    err_hit      = 1'b0;
    err_kind     = E_NONE;

    if (bus.stuff_err && bus.unstuff_en) begin
      err_hit  = 1'b1;
      err_kind = E_STUFF;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.bit_in) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == IW'(IDLE_BITS - 1)) begin
            idle_cnt_d = '0;
            state_d    = S_WAIT_SOF;
          end else begin
            idle_cnt_d = idle_cnt_q + IW'(1);
          end
        end
        S_WAIT_SOF: begin
          if (!bus.bit_in) begin
            state_d    = S_ARB;
            cnt_d      = '0;
            err_code_d = E_NONE;
            id_d       = '0;
            rtr_d      = 1'b0;
            dlc_d      = '0;
            ack_seen_d = 1'b0;
          end
        end
        S_ARB: begin
          if (cnt_q == CW'(11)) begin
            rtr_d   = bus.bit_in;
            cnt_d   = '0;
            state_d = S_CTRL;
          end else begin
            id_d  = {id_q[9:0], bus.bit_in};
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CTRL: begin
          // Field order: IDE, r0, DLC[3:0].
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(0) && bus.bit_in) begin
            err_hit  = 1'b1;
            err_kind = E_FORM;
          end
          if (cnt_q >= CW'(2)) dlc_d = dlc_next;
          if (cnt_q == CW'(5)) begin
            cnt_d   = '0;
            bytes_d = nbytes;
            state_d = (nbytes == 4'd0) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          shift_d = {shift_q[5:0], bus.bit_in};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(7)) begin
            data_byte_d  = {shift_q, bus.bit_in};
            data_valid_d = 1'b1;
            cnt_d        = '0;
            bytes_d      = bytes_q - 4'd1;
            if (bytes_q == 4'd1) state_d = S_CRC;
          end
        end
        S_CRC: begin
          if (cnt_q == CW'(CRC_BITS - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC_DEL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_CRC_DEL: begin
          if (!bus.bit_in) begin
            err_hit  = 1'b1;
            err_kind = E_FORM;
          end else if (bus.crc_remainder != '0) begin
            err_hit  = 1'b1;
            err_kind = E_CRC;
          end else begin
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          ack_seen_d = !bus.bit_in;
          state_d    = S_ACK_DEL;
        end
        S_ACK_DEL: begin
          if (!bus.bit_in) begin
            err_hit  = 1'b1;
            err_kind = E_FORM;
          end else begin
            cnt_d   = '0;
            state_d = S_EOF;
          end
        end
        S_EOF: begin
          if (!bus.bit_in) begin
            err_hit  = 1'b1;
            err_kind = E_FORM;
          end else if (cnt_q == CW'(6)) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = S_WAIT_SOF;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Any error abandons the frame and demands a fresh recessive idle run.
    if (err_hit) begin
      state_d     = S_IDLE;
      idle_cnt_d  = '0;
      cnt_d       = '0;
      frame_err_d = 1'b1;
      err_code_d  = err_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idle_cnt_q   <= '0;
      cnt_q        <= '0;
      bytes_q      <= '0;
      shift_q      <= '0;
      id_q         <= '0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      data_byte_q  <= '0;
      data_valid_q <= 1'b0;
      ack_seen_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= E_NONE;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      cnt_q        <= cnt_d;
      bytes_q      <= bytes_d;
      shift_q      <= shift_d;
      id_q         <= id_d;
      rtr_q        <= rtr_d;
      dlc_q        <= dlc_d;
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      ack_seen_q   <= ack_seen_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.unstuff_en = in_frame || sof;
  assign bus.crc_en     = in_frame || sof;
  assign bus.crc_clear  = sof;
  assign bus.id         = id_q;
  assign bus.rtr        = rtr_q;
  assign bus.dlc        = dlc_q;
  assign bus.data_byte  = data_byte_q;
  assign bus.data_valid = data_valid_q;
  assign bus.ack_seen   = ack_seen_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_can_rx_sequencer.sv
// Bench for can_rx_sequencer: directed frame table, hand-written reset/idle sequences, and random frames vs a field-level model.
module tb_can_rx_sequencer;
  localparam int CRC_BITS  = 15;
  localparam int IDLE_BITS = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  can_rx_sequencer_if #(.CRC_BITS(CRC_BITS)) bus ();
  can_rx_sequencer #(.CRC_BITS(CRC_BITS), .IDLE_BITS(IDLE_BITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         nbytes;
    logic [7:0] b0;
    logic [1:0] err;
    int         done;
    int         ferr;
    logic       ack;
  } exp_t;

  // mode 0 clean, 1 bit flip caught by CRC, 2 bit flip caught as form error, 3 stuff_err with bit pos
  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        ack;
    int          mode;
    int          pos;
    exp_t        e;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_done, n_ferr, n_clr;
  logic [7:0] got_q[$];
  bit fq[$];
  logic [14:0] crc_m;
  vec_t tbl[10];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    c = {c[13:0], 1'b0};
    if (fb) c = c ^ 15'h4599;
    return c;
  endfunction

  function automatic logic [32:0] outs();
    return {bus.unstuff_en, bus.crc_clear, bus.crc_en, bus.id, bus.rtr, bus.dlc, bus.data_byte,
            bus.data_valid, bus.ack_seen, bus.frame_done, bus.frame_err, bus.err_code};
  endfunction

  function automatic int bytes_of(input logic rtr, input logic [3:0] dlc);
    return rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
  endfunction

  function automatic vec_t mkv(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                               input logic [63:0] data, input logic ack, input int mode, input int pos,
                               input int nbytes, input logic [7:0] b0, input logic [1:0] err,
                               input int done, input int ferr, input logic eack);
    vec_t v;
    v.id = id; v.rtr = rtr; v.dlc = dlc; v.data = data; v.ack = ack; v.mode = mode; v.pos = pos;
    v.e.nbytes = nbytes; v.e.b0 = b0; v.e.err = err; v.e.done = done; v.e.ferr = ferr; v.e.ack = eack;
    return v;
  endfunction

  // Reference outcome from field positions: SOF=0, ID 1..11, RTR 12, IDE 13, r0 14, DLC 15..18, data from 19.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int nb;
    nb = bytes_of(v.rtr, v.dlc);
    e.nbytes = nb;
    if (v.mode >= 2) begin
      e.nbytes = 0;
      for (int j = 0; j < nb; j++) if (19 + 8 * j + 7 < v.pos) e.nbytes++;
    end
    e.b0   = v.data[63:56];
    e.err  = (v.mode == 0) ? 2'b00 : (v.mode == 1) ? 2'b11 : (v.mode == 2) ? 2'b10 : 2'b01;
    e.done = (v.mode == 0) ? 1 : 0;
    e.ferr = (v.mode == 0) ? 0 : 1;
    e.ack  = v.ack;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.data_valid) got_q.push_back(bus.data_byte);
    if (bus.frame_done) n_done++;
    if (bus.frame_err) n_ferr++;
  end

  // Drives one strobed bit and plays the CRC block using the DUT's gating for that bit.
  task automatic send_bit(input logic b, input logic serr);
    logic en, clr;
    @(negedge clk);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    bus.stuff_err = serr;
    #1;
    en  = bus.crc_en;
    clr = bus.crc_clear;
    if (clr) n_clr++;
    @(posedge clk);
    if (clr) crc_m = '0;
    if (en) crc_m = crc_step(crc_m, b);
    #1;
    bus.crc_remainder = crc_m;
    bus.bit_valid     = 1'b0;
    bus.stuff_err     = 1'b0;
    bus.bit_in        = 1'($urandom_range(0, 1));
  endtask

  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input logic ack, output int nb);
    logic [14:0] c;
    logic [7:0]  bt;
    fq.delete();
    nb = bytes_of(rtr, dlc);
    fq.push_back(1'b0);
    for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
    fq.push_back(rtr);
    fq.push_back(1'b0);
    fq.push_back(1'b0);
    for (int i = 3; i >= 0; i--) fq.push_back(dlc[i]);
    for (int j = 0; j < nb; j++) begin
      bt = data[63 - 8 * j -: 8];
      for (int i = 7; i >= 0; i--) fq.push_back(bt[i]);
    end
    c = '0;
    foreach (fq[i]) c = crc_step(c, fq[i]);
    for (int i = 14; i >= 0; i--) fq.push_back(c[i]);
    fq.push_back(1'b1);
    fq.push_back(!ack);
    fq.push_back(1'b1);
    for (int i = 0; i < 7; i++) fq.push_back(1'b1);
  endtask

  task automatic run_vec(input vec_t v, input bit gaps, input string tag);
    int nb, stop, crc_del;
    build_frame(v.id, v.rtr, v.dlc, v.data, v.ack, nb);
    crc_del = 19 + 8 * nb + CRC_BITS;
    if (v.mode == 1 || v.mode == 2) fq[v.pos] = ~fq[v.pos];
    case (v.mode)
      0:       stop = fq.size() - 1;
      1:       stop = crc_del;
      default: stop = v.pos;
    endcase
    repeat (IDLE_BITS) send_bit(1'b1, 1'b0);
    got_q.delete();
    n_done = 0;
    n_ferr = 0;
    for (int i = 0; i <= stop; i++) begin
      send_bit(fq[i], (v.mode == 3) && (i == v.pos));
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_nbytes"}, got_q.size(), v.e.nbytes);
    if (got_q.size() > 0 && v.e.nbytes > 0) chk({tag, "_byte0"}, got_q[0], v.e.b0);
    for (int j = 1; j < got_q.size() && j < v.e.nbytes; j++)
      chk($sformatf("%s_byte%0d", tag, j), got_q[j], v.data[63 - 8 * j -: 8]);
    chk({tag, "_err_code"}, bus.err_code, v.e.err);
    chk({tag, "_frame_done"}, n_done, v.e.done);
    chk({tag, "_frame_err"}, n_ferr, v.e.ferr);
    if (v.mode == 0) begin
      chk({tag, "_id"}, bus.id, v.id);
      chk({tag, "_rtr"}, bus.rtr, v.rtr);
      chk({tag, "_dlc"}, bus.dlc, v.dlc);
      chk({tag, "_ack_seen"}, bus.ack_seen, v.e.ack);
    end
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in = 1'b1;
    bus.stuff_err = 1'b0;
    bus.crc_remainder = '0;
    crc_m = '0;
    n_clr = 0;

    tbl[0] = mkv(11'h123, 0, 4'd2, 64'hA53C_0000_0000_0000, 1, 0, 0, 2, 8'hA5, 2'b00, 1, 0, 1);
    tbl[1] = mkv(11'h123, 0, 4'd2, 64'hA53C_0000_0000_0000, 1, 1, 22, 2, 8'hB5, 2'b11, 0, 1, 1);
    tbl[2] = mkv(11'h2AA, 1, 4'd4, 64'hFFFF_FFFF_0000_0000, 1, 0, 0, 0, 8'h00, 2'b00, 1, 0, 1);
    tbl[3] = mkv(11'h123, 0, 4'd2, 64'hA53C_0000_0000_0000, 1, 3, 5, 0, 8'h00, 2'b01, 0, 1, 1);
    tbl[4] = mkv(11'h7F0, 0, 4'hF, 64'h0102_0304_0506_0708, 1, 0, 0, 8, 8'h01, 2'b00, 1, 0, 1);
    tbl[5] = mkv(11'h7F0, 0, 4'hF, 64'h0102_0304_0506_0708, 1, 2, 104, 8, 8'h01, 2'b10, 0, 1, 1);
    tbl[6] = mkv(11'h000, 0, 4'd0, 64'h0, 0, 0, 0, 0, 8'h00, 2'b00, 1, 0, 0);
    tbl[7] = mkv(11'h555, 0, 4'd1, 64'h5A00_0000_0000_0000, 1, 2, 13, 0, 8'h00, 2'b10, 0, 1, 1);
    tbl[8] = mkv(11'h555, 0, 4'd1, 64'h5A00_0000_0000_0000, 1, 2, 42, 1, 8'h5A, 2'b10, 0, 1, 1);
    tbl[9] = mkv(11'h0F1, 1, 4'd9, 64'h1234_0000_0000_0000, 1, 0, 0, 0, 8'h00, 2'b00, 1, 0, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outs(), 0);

    for (int t = 0; t < 10; t++) run_vec(tbl[t], 1'b0, $sformatf("tbl%0d", t));

    // Stuff error, then an SOF after only 5 recessive bits must be ignored.
    run_vec(tbl[3], 1'b0, "stuff_arb");
    n_clr = 0;
    repeat (5) send_bit(1'b1, 1'b0);
    build_frame(tbl[0].id, tbl[0].rtr, tbl[0].dlc, tbl[0].data, tbl[0].ack, nb);
    got_q.delete();
    n_ferr = 0;
    for (int i = 0; i < 19 + 16; i++) send_bit(fq[i], 1'b0);
    repeat (2) @(negedge clk);
    chk("short_idle_sof_clear", n_clr, 0);
    chk("short_idle_no_data", got_q.size(), 0);
    chk("short_idle_no_err", n_ferr, 0);
    run_vec(tbl[0], 1'b0, "after_full_idle");
    chk("full_idle_sof_clear", n_clr, 1);

    // Reset in the middle of DATA.
    repeat (IDLE_BITS) send_bit(1'b1, 1'b0);
    build_frame(tbl[0].id, tbl[0].rtr, tbl[0].dlc, tbl[0].data, tbl[0].ack, nb);
    for (int i = 0; i <= 19 + 8 + 3; i++) send_bit(fq[i], 1'b0);
    got_q.delete();
    n_done = 0;
    n_ferr = 0;
    @(negedge clk);
    rst = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.bit_valid = 1'b0;
    crc_m = '0;
    bus.crc_remainder = '0;
    @(negedge clk);
    chk("rst_mid_outputs", outs(), 0);
    n_clr = 0;
    for (int i = 0; i < 4; i++) send_bit(fq[i], 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_mid_sof_ignored", n_clr, 0);
    chk("rst_mid_no_pulses", got_q.size() + n_done + n_ferr, 0);
    run_vec(tbl[4], 1'b1, "after_rst");

    for (int k = 0; k < 40; k++) begin
      vec_t v;
      int cd;
      v.id   = 11'($urandom);
      v.rtr  = ($urandom_range(0, 3) == 0);
      v.dlc  = 4'($urandom);
      v.data = {$urandom, $urandom};
      v.ack  = 1'($urandom_range(0, 1));
      v.mode = $urandom_range(0, 3);
      cd = 19 + 8 * bytes_of(v.rtr, v.dlc) + CRC_BITS;
      case (v.mode)
        1: v.pos = $urandom_range(1, 11);
        2: case ($urandom_range(0, 3))
             0:       v.pos = 13;
             1:       v.pos = cd;
             2:       v.pos = cd + 2;
             default: v.pos = cd + 3 + $urandom_range(0, 6);
           endcase
        3: v.pos = $urandom_range(0, cd - 1);
        default: v.pos = 0;
      endcase
      v.e = model(v);
      run_vec(v, 1'b1, $sformatf("rnd%0d_m%0d", k, v.mode));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
